// File: rtl/dmem_access_unit.sv
// Memory-stage load/store unit: byte-laned bus requests, pipeline freeze, load extension.
// Optional stall-cycle counter enabled by defining DMEM_STALL_COUNT_EN.
module dmem_access_unit #(
    parameter logic [31:0] ADDR_MASK = 32'h1FFF_FFFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        memreqM,
    input  logic        memwriteM,
    input  logic [1:0]  memsizeM,
    input  logic        memsignedM,
    input  logic [31:0] addrM,
    input  logic [31:0] writedataM,
    output logic [31:0] readdataM,
    output logic        stallM,
    output logic        adelM,
    output logic        adesM,
    output logic        data_req,
    output logic        data_wr,
    output logic [1:0]  data_size,
    output logic [31:0] data_addr,
    output logic [3:0]  data_wstrb,
    output logic [31:0] data_wdata,
    input  logic        data_addr_ok,
    input  logic        data_data_ok,
    input  logic [31:0] data_rdata,
    output logic [31:0] stall_cnt
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_DONE
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [31:0] r_rdata;
    logic [31:0] w_ext;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic        w_is_half;
    logic        w_is_word;
    logic        w_misalign;
    logic        w_capture;

    assign w_is_half  = (memsizeM == 2'd1);
    assign w_is_word  = memsizeM[1];
    assign w_misalign = (w_is_half && addrM[0])
                      || (w_is_word && (addrM[1:0] != 2'b00));

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next    = r_state;
        stallM    = 1'b0;
        data_req  = 1'b0;
        adelM     = 1'b0;
        adesM     = 1'b0;
        w_capture = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (memreqM) begin
                    if (w_misalign) begin
                        adelM = ~memwriteM;
                        adesM = memwriteM;
                    end else begin
                        stallM = 1'b1;
                        w_next = S_REQ;
                    end
                end
            end
            S_REQ: begin
                data_req = 1'b1;
                stallM   = 1'b1;
                if (data_addr_ok && data_data_ok) begin
                    w_capture = 1'b1;
                    w_next    = S_DONE;
                end else if (data_addr_ok) begin
                    w_next = S_WAIT;
                end
            end
            S_WAIT: begin
                stallM = 1'b1;
                if (data_data_ok) begin
                    w_capture = 1'b1;
                    w_next    = S_DONE;
                end
            end
            S_DONE: begin
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Extension is done at capture time; addrM/size are frozen by the stall.
    always_comb begin
        w_byte = data_rdata[7:0];
        unique case (addrM[1:0])
            2'd0: w_byte = data_rdata[7:0];
            2'd1: w_byte = data_rdata[15:8];
            2'd2: w_byte = data_rdata[23:16];
            2'd3: w_byte = data_rdata[31:24];
            default: w_byte = data_rdata[7:0];
        endcase
        w_half = addrM[1] ? data_rdata[31:16] : data_rdata[15:0];
        if (w_is_word)
            w_ext = data_rdata;
        else if (w_is_half)
            w_ext = {{16{memsignedM & w_half[15]}}, w_half};
        else
            w_ext = {{24{memsignedM & w_byte[7]}}, w_byte};
    end

    always_ff @(posedge clk) begin
        if (rst)
            r_rdata <= 32'd0;
        else if (w_capture && !memwriteM)
            r_rdata <= w_ext;
    end

    assign readdataM = r_rdata;
    assign data_wr   = memwriteM;
    assign data_size = w_is_word ? 2'd2 : memsizeM;
    assign data_addr = addrM & ADDR_MASK;

    always_comb begin
        data_wstrb = 4'b0000;
        data_wdata = writedataM;
        if (w_is_word) begin
            data_wdata = writedataM;
            if (memwriteM) data_wstrb = 4'hF;
        end else if (w_is_half) begin
            data_wdata = {2{writedataM[15:0]}};
            if (memwriteM) data_wstrb = addrM[1] ? 4'b1100 : 4'b0011;
        end else begin
            data_wdata = {4{writedataM[7:0]}};
            if (memwriteM) data_wstrb = 4'b0001 << addrM[1:0];
        end
    end

`ifdef DMEM_STALL_COUNT_EN
    logic [31:0] r_stall_cnt;

    always_ff @(posedge clk) begin
        if (rst)
            r_stall_cnt <= 32'd0;
        else if (stallM)
            r_stall_cnt <= r_stall_cnt + 32'd1;
    end

    assign stall_cnt = r_stall_cnt;
`else
    assign stall_cnt = 32'd0;
`endif

endmodule
